// File: rtl/gray_ticket_arbiter_if.sv
// Request/grant bundle between requesters and the Gray ticket arbiter.
// The arbiter drives only grant-side signals; requesters drive en, req and ack.
interface gray_ticket_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             en;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic [CBITS-1:0] ticket;
    logic             busy;
    logic             timeout;
    logic             wrap;
    logic             zero;
    // Observation of internal FSM state and priority pointer.
    logic             dbg_state;
    logic [IDW-1:0]   dbg_ptr;

    modport master (
        output en, req, ack,
        input  gnt, gnt_id, ticket, busy, timeout, wrap, zero, dbg_state, dbg_ptr
    );

    modport slave (
        input  en, req, ack,
        output gnt, gnt_id, ticket, busy, timeout, wrap, zero, dbg_state, dbg_ptr
    );
endinterface

// File: rtl/gray_ticket_arbiter.sv
// Round-robin arbiter handing out Gray-coded tickets from one shared counter.
// Handshake: a grant is held until ack[gnt_id] is sampled high or TIMEOUT cycles pass.
module gray_ticket_arbiter #(
    parameter int NREQ    = 4,
    parameter int CBITS   = 8,
    parameter int TIMEOUT = 8
) (
    input logic                clk,
    input logic                rst,
    gray_ticket_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [CBITS-1:0] cnt_q,     cnt_d;
    logic [IDW-1:0]   ptr_q,     ptr_d;
    logic [TW-1:0]    tmr_q,     tmr_d;
    logic [NREQ-1:0]  gnt_q,     gnt_d;
    logic [IDW-1:0]   gnt_id_q,  gnt_id_d;
    logic             timeout_q, timeout_d;
    logic             wrap_q,    wrap_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   ptr_after;
    logic             ack_hit;
    logic             tmr_expired;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_after   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
    assign ack_hit     = bus.ack[gnt_id_q];
    assign tmr_expired = (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        tmr_d     = tmr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (bus.en && win_found) begin
                    gnt_d    = NREQ'(1) << win_idx;
                    gnt_id_d = win_idx;
                    tmr_d    = '0;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // Ack outranks the timer, so a last-cycle ack still consumes.
                if (ack_hit) begin
                    cnt_d   = cnt_q + CBITS'(1);
                    wrap_d  = (cnt_q == '1);
                    ptr_d   = ptr_after;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    ptr_d     = ptr_after;
                    gnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            tmr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            tmr_q     <= tmr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.ticket    = cnt_q ^ (cnt_q >> 1);
    assign bus.busy      = (state_q == S_GRANT);
    assign bus.timeout   = timeout_q;
    assign bus.wrap      = wrap_q;
    assign bus.zero      = (cnt_q == '0) & ~rst;
    assign bus.dbg_state = state_q;
    assign bus.dbg_ptr   = ptr_q;

    a_busy_gnt : assert property (@(posedge clk) disable iff (rst)
        bus.busy == (bus.gnt != '0));
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.gnt));
    a_pulse_excl : assert property (@(posedge clk) disable iff (rst)
        !(bus.timeout && bus.wrap));
endmodule

// File: tb/tb_gray_ticket_arbiter.sv
// Directed bench for gray_ticket_arbiter: driver pushes expected grant/release
// records, a negedge monitor pops and compares them as the DUT presents them.
module tb_gray_ticket_arbiter;
  localparam int NREQ = 4;
  localparam int CBITS = 4;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  gray_ticket_arbiter_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

  gray_ticket_arbiter #(.NREQ(NREQ), .CBITS(CBITS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Hand-written 4-bit reflected Gray sequence.
  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  int errors = 0;
  int checks = 0;
  int n_model = 0;

  // grant record: {gnt, gnt_id, ticket, zero}; release record: {len, timeout, wrap, ticket, zero}
  logic [10:0] exp_gnt_q [$];
  logic [10:0] exp_end_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.ack = '0;
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_gnt_id", bus.gnt_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ticket", bus.ticket, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_state", bus.dbg_state, 0);
    check("rst_ptr", bus.dbg_ptr, 0);
    rst = 1'b0;
    n_model = 0;
    #1;
    check("zero_after_rst", bus.zero, 1);
  endtask

  // ---------------- driver ----------------
  // mode 0: ack at once; 1: never ack; 2: ack on last timer cycle;
  // 3: non-grantee acks for 3 cycles then ack; 4: drop en mid-grant then ack;
  // 5: assert rst mid-grant.
  task automatic run_grant(input logic [3:0] req_v, input logic [3:0] req_after,
                           input int exp_id, input int mode);
    int k0, k1, len, waited;
    logic [3:0] gm, t0, t1;
    logic z0, z1, consumed, to, wr;
    gm = 4'b0001 << exp_id;
    k0 = n_model % 16;
    t0 = gray_tbl[k0];
    z0 = (k0 == 0);
    consumed = (mode != 1) && (mode != 5);
    to = (mode == 1);
    case (mode)
      0: len = 1;
      1, 2: len = 8;
      3: len = 4;
      default: len = 3;
    endcase
    if (consumed) n_model++;
    k1 = n_model % 16;
    t1 = gray_tbl[k1];
    z1 = (k1 == 0);
    wr = consumed && (k0 == 15);
    exp_gnt_q.push_back({gm, 2'(exp_id), t0, z0});
    if (mode != 5) exp_end_q.push_back({4'(len), to, wr, t1, z1});

    bus.req = req_v;
    bus.en = 1'b1;
    #2;
    check("no_comb_path", bus.gnt, 0);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (bus.gnt == '0 && waited < 20);
    check("grant_latency", waited, 1);
    if (bus.gnt == '0) return;
    bus.req = req_after;

    case (mode)
      0: begin
        bus.ack = gm;
        @(posedge clk); #1;
        bus.ack = '0;
      end
      1: begin
        waited = 0;
        do begin
          @(posedge clk); #1;
          waited++;
        end while (bus.gnt != '0 && waited < 20);
      end
      2: begin
        repeat (7) begin @(posedge clk); #1; end
        bus.ack = gm;
        @(posedge clk); #1;
        bus.ack = '0;
      end
      3: begin
        bus.ack = ~gm;
        repeat (3) begin @(posedge clk); #1; end
        bus.ack = gm;
        @(posedge clk); #1;
        bus.ack = '0;
      end
      4: begin
        bus.en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.ack = gm;
        @(posedge clk); #1;
        bus.ack = '0;
      end
      default: begin
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_gnt", bus.gnt, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ticket", bus.ticket, 0);
        check("midrst_zero", bus.zero, 0);
        check("midrst_ptr", bus.dbg_ptr, 0);
        n_model = 0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_busy;
    int len;
    logic [10:0] exp_v;
    prev_busy = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        len = 0;
      end else begin
        check("busy_vs_gnt", bus.busy, (bus.gnt != '0));
        if (bus.busy && !prev_busy) begin
          len = 1;
          checks++;
          if (exp_gnt_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected got=%0h exp=none", bus.gnt);
          end else begin
            exp_v = exp_gnt_q.pop_front();
            checks--;
            check("grant_rec", {bus.gnt, bus.gnt_id, bus.ticket, bus.zero}, exp_v);
          end
        end else if (bus.busy) begin
          len++;
        end else if (prev_busy) begin
          checks++;
          if (exp_end_q.size() == 0) begin
            errors++;
            $display("FAIL release_unexpected got=%0h exp=none", bus.ticket);
          end else begin
            exp_v = exp_end_q.pop_front();
            checks--;
            check("release_rec", {4'(len), bus.timeout, bus.wrap, bus.ticket, bus.zero}, exp_v);
          end
        end else begin
          check("idle_pulses", {bus.timeout, bus.wrap}, 0);
        end
        prev_busy = bus.busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.ack = '0;
    bus.en = 1'b0;
    do_reset();
    @(posedge clk); #1;

    // single requester
    run_grant(4'b0001, 4'b0000, 0, 0);
    repeat (2) begin @(posedge clk); #1; end

    // round robin from reset: ids 0,1,2,3,0, tickets 0,1,3,2,6
    do_reset();
    @(posedge clk); #1;
    run_grant(4'b1111, 4'b1111, 0, 0);
    run_grant(4'b1111, 4'b1111, 1, 0);
    run_grant(4'b1111, 4'b1111, 2, 0);
    run_grant(4'b1111, 4'b1111, 3, 0);
    run_grant(4'b1111, 4'b0000, 0, 0);
    repeat (2) begin @(posedge clk); #1; end

    // timeout: requester 2 never acks, pointer then favours 3
    run_grant(4'b0100, 4'b1100, 2, 1);
    check("timeout_ptr", bus.dbg_ptr, 3);
    run_grant(4'b1100, 4'b0000, 3, 0);
    repeat (2) begin @(posedge clk); #1; end

    // ack on the timeout cycle, then non-grantee acks
    run_grant(4'b0010, 4'b0000, 1, 2);
    repeat (2) begin @(posedge clk); #1; end
    run_grant(4'b0001, 4'b0000, 0, 3);
    repeat (2) begin @(posedge clk); #1; end

    // en dropped mid-grant: no new grant while en=0
    run_grant(4'b0010, 4'b1111, 1, 4);
    repeat (3) begin
      @(posedge clk); #1;
      check("en_block", bus.gnt, 0);
    end

    // reset mid-grant, then confirm ptr and cnt restarted
    run_grant(4'b1111, 4'b0000, 2, 5);
    @(posedge clk); #1;
    run_grant(4'b1111, 4'b0000, 0, 0);
    repeat (2) begin @(posedge clk); #1; end

    // wrap: 16 consumed tickets from reset
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) run_grant(4'b0001, 4'b0000, 0, 0);
    repeat (4) begin @(posedge clk); #1; end

    check("gnt_q_drained", exp_gnt_q.size(), 0);
    check("end_q_drained", exp_end_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
